hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard/stall controller for the 5-stage WISC core; drives the stalls the EX forwarding unit depends on.
//  Detects load-use and flag/branch-register hazards and freezes or bubbles pipeline registers on I/D-cache misses.
//  Latches HLT; sits beside decode and drives write-enables/flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// PARAMETERS
//  REGW   4   register address width
//  CNTW   16  perf counter width (used only with HAZ_PERF_EN)
// PORTS
//  clk          in   1     core clock
//  rst_n        in   1     asynchronous active-low reset
//  d_rs,d_rt    in   REGW  decode-stage source register addresses
//  d_rs_en      in   1     decode instr reads rs
//  d_rt_en      in   1     decode instr reads rt
//  d_br_cond    in   1     decode instr is conditional B/BR (reads flags)
//  d_br_reg     in   1     decode instr is BR (reads rs as target)
//  d_br_taken   in   1     branch resolved taken in decode
//  d_halt       in   1     decode instr is HLT
//  x_rd         in   REGW  EX-stage destination
//  x_regwr      in   1     EX instr writes register
//  x_memrd      in   1     EX instr is LW
//  x_setflags   in   1     EX instr updates flags
//  m_rd         in   REGW  MEM-stage destination
//  m_memrd      in   1     MEM instr is LW
//  imiss,dmiss  in   1     I/D-cache miss busy (level, held until fill done)
//  pc_we        out  1     PC write enable
//  ifid_we      out  1     IF/ID write enable
//  ifid_flush   out  1     load NOP into IF/ID
//  idex_bubble  out  1     load NOP into ID/EX
//  exmem_we     out  1     EX/MEM write enable
//  memwb_we     out  1     MEM/WB write enable
//  halted       out  1     HLT reached; front end frozen
//  state        out  2     FSM state (debug)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=RUN, halted=0; all *_we=1, ifid_flush=idex_bubble=0. Outputs combinational from state+inputs.
//  Addr 0 never causes a hazard.
//  Hazards (eval in RUN only):
//   LU   x_memrd&x_regwr&x_rd!=0&((d_rs_en&d_rs==x_rd)|(d_rt_en&d_rt==x_rd))
//   FLG  d_br_cond&x_setflags
//   BRR  d_br_reg&d_rs!=0&((x_regwr&d_rs==x_rd)|(m_memrd&d_rs==m_rd))
//   haz=LU|FLG|BRR -> pc_we=ifid_we=0, idex_bubble=1, exmem/memwb_we=1; one cycle per eval; repeats while haz holds.
//  FSM (RUN, DMISS, IMISS, HALT), priority dmiss > imiss > haz > branch:
//   RUN->DMISS on dmiss: all we=0, no bubble/flush (full freeze); stay while dmiss; ->RUN the cycle after dmiss falls.
//   RUN->IMISS on imiss&!dmiss: pc_we=ifid_we=0, ifid_flush=1, back end runs; dmiss in IMISS -> DMISS; imiss low -> RUN.
//   In IMISS a taken branch in ID: pc_we=1, ifid_flush=1 (redirect); haz in ID still bubbles.
//   d_br_taken in RUN without haz: ifid_flush=1, pc_we=1. Taken branch with haz: stall wins, branch re-evaluated.
//   d_halt in RUN without haz -> HALT, halted=1: pc_we=ifid_we=0, ifid_flush=1, back end drains; only rst_n exits.
//   Same-cycle imiss+dmiss from RUN -> DMISS; imiss still high on exit -> IMISS.
//  Reset mid-miss returns to RUN immediately; caches own their own abort.
// CONFIGURATION
//  HAZ_PERF_EN defined: CNTW-bit saturating counters (ports cnt_lu, cnt_dmiss, cnt_imiss, out) of cycles in LU stall,
//   DMISS, IMISS; clear on reset; hold at all-ones. Undefined: ports absent, no logic; all other behaviour identical.
// STRUCTURE
//  Package wisc_pipe_pkg: haz_state_t enum {RUN=0,DMISS=1,IMISS=2,HALT=3}, REG_ZERO constant, REGW default.
//  Sub-module sat_counter (width param, inc, clr) instantiated x3 under HAZ_PERF_EN.
// TESTING
//  LW R3 in EX, ADD reads R3 in ID -> 1 cycle pc_we=0, idex_bubble=1, then pc_we=1.
//  LW R0 in EX, ID reads R0 -> no stall; x_rd=5, d_rt_en=0, d_rt=5 -> no stall.
//  dmiss high 10 cycles -> state=DMISS, all we=0 for 10 cycles, RUN on cycle 11.
//  imiss 4 cycles, taken branch in ID on cycle 2 -> ifid_flush=1 all 4, pc_we=1 only cycle 2.
//  imiss+dmiss same cycle, dmiss drops first -> DMISS then IMISS then RUN.
//  HLT in ID -> halted=1, pc_we=0 thereafter; rst_n pulse -> RUN, halted=0. HAZ_PERF_EN: 3 LU stalls -> cnt_lu=3.

Source files
------------

// File: rtl/wisc_pipe_pkg.sv
// Shared types and constants for the WISC pipeline control logic.
package wisc_pipe_pkg;

  localparam int unsigned REGW_DEFAULT = 4;

  // Register 0 is hardwired; it never creates a dependency.
  localparam logic [REGW_DEFAULT-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DMISS = 2'd1,
    IMISS = 2'd2,
    HALT  = 2'd3
  } haz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear wins, then increment unless already all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage WISC core.
// Optional HAZ_PERF_EN adds saturating stall/miss cycle counters.
module hazard_ctrl
  import wisc_pipe_pkg::*;
#(
  parameter int unsigned REGW = REGW_DEFAULT,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [REGW-1:0] d_rs,
  input  logic [REGW-1:0] d_rt,
  input  logic            d_rs_en,
  input  logic            d_rt_en,
  input  logic            d_br_cond,
  input  logic            d_br_reg,
  input  logic            d_br_taken,
  input  logic            d_halt,
  input  logic [REGW-1:0] x_rd,
  input  logic            x_regwr,
  input  logic            x_memrd,
  input  logic            x_setflags,
  input  logic [REGW-1:0] m_rd,
  input  logic            m_memrd,
  input  logic            imiss,
  input  logic            dmiss,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic            exmem_we,
  output logic            memwb_we,
  output logic            halted,
  output logic [1:0]      state
`ifdef HAZ_PERF_EN
  ,
  output logic [CNTW-1:0] cnt_lu,
  output logic [CNTW-1:0] cnt_dmiss,
  output logic [CNTW-1:0] cnt_imiss
`endif
);

  haz_state_t state_q, state_d;
  logic       lu, flg, brr, haz;

  // Dependency checks against the instructions in EX and MEM.
  always_comb begin
    lu  = x_memrd && x_regwr && (x_rd != '0) &&
          ((d_rs_en && (d_rs == x_rd)) || (d_rt_en && (d_rt == x_rd)));
    flg = d_br_cond && x_setflags;
    brr = d_br_reg && (d_rs != '0) &&
          ((x_regwr && (d_rs == x_rd)) || (m_memrd && (d_rs == m_rd)));
    haz = lu || flg || brr;
  end

  // Next state and pipeline-register controls; dmiss > imiss > hazard > branch/halt.
  always_comb begin
    state_d     = state_q;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    if (state_q == HALT) begin
      // Front end stays frozen; back end drains unless the D-cache is busy.
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      if (dmiss) begin
        exmem_we = 1'b0;
        memwb_we = 1'b0;
      end else begin
        ifid_flush = 1'b1;
      end
    end else if (dmiss) begin
      state_d  = DMISS;
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (imiss) begin
      // No valid fetch: IF/ID gets a NOP, but decode may still issue or redirect.
      state_d = IMISS;
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      if (haz) begin
        idex_bubble = 1'b1;
      end else begin
        ifid_flush = 1'b1;
        if (d_br_taken) begin
          pc_we = 1'b1;
        end else if (d_halt) begin
          state_d = HALT;
        end
      end
    end else begin
      state_d = RUN;
      if (haz) begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end else if (d_br_taken) begin
        ifid_flush = 1'b1;
      end else if (d_halt) begin
        state_d    = HALT;
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  // State register; reset aborts any miss wait immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign halted = (state_q == HALT);
  assign state  = state_q;

`ifdef HAZ_PERF_EN
  logic lu_stall;
  // A load-use cycle counts only when the stall is actually applied.
  assign lu_stall = lu && (state_q != HALT) && !dmiss;

  sat_counter #(.WIDTH(CNTW)) u_cnt_lu (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (1'b0),
    .inc  (lu_stall),
    .count(cnt_lu)
  );

  sat_counter #(.WIDTH(CNTW)) u_cnt_dmiss (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (1'b0),
    .inc  (state_q == DMISS),
    .count(cnt_dmiss)
  );

  sat_counter #(.WIDTH(CNTW)) u_cnt_imiss (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (1'b0),
    .inc  (state_q == IMISS),
    .count(cnt_imiss)
  );
`else
  // Counter width only matters when the counters are built.
  logic [31:0] unused_cntw;
  assign unused_cntw = CNTW;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// stimulus against a behavioural model. Build with HAZ_PERF_EN to cover counters.
module tb_hazard_ctrl;

  localparam int REGW = 4;
  localparam int CNTW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [REGW-1:0] d_rs, d_rt, x_rd, m_rd;
  logic d_rs_en, d_rt_en, d_br_cond, d_br_reg, d_br_taken, d_halt;
  logic x_regwr, x_memrd, x_setflags, m_memrd, imiss, dmiss;
  logic pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we, halted;
  logic [1:0] state;
`ifdef HAZ_PERF_EN
  logic [CNTW-1:0] cnt_lu, cnt_dmiss, cnt_imiss;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_rs_en    (d_rs_en),
    .d_rt_en    (d_rt_en),
    .d_br_cond  (d_br_cond),
    .d_br_reg   (d_br_reg),
    .d_br_taken (d_br_taken),
    .d_halt     (d_halt),
    .x_rd       (x_rd),
    .x_regwr    (x_regwr),
    .x_memrd    (x_memrd),
    .x_setflags (x_setflags),
    .m_rd       (m_rd),
    .m_memrd    (m_memrd),
    .imiss      (imiss),
    .dmiss      (dmiss),
    .pc_we      (pc_we),
    .ifid_we    (ifid_we),
    .ifid_flush (ifid_flush),
    .idex_bubble(idex_bubble),
    .exmem_we   (exmem_we),
    .memwb_we   (memwb_we),
    .halted     (halted),
    .state      (state)
`ifdef HAZ_PERF_EN
    ,
    .cnt_lu     (cnt_lu),
    .cnt_dmiss  (cnt_dmiss),
    .cnt_imiss  (cnt_imiss)
`endif
  );

  // Packed view of all control outputs: {pc,ifid,flush,bubble,exmem,memwb}.
  wire [5:0] ctl = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_we};

  task automatic idle();
    d_rs = '0; d_rt = '0; x_rd = '0; m_rd = '0;
    d_rs_en = 0; d_rt_en = 0; d_br_cond = 0; d_br_reg = 0; d_br_taken = 0; d_halt = 0;
    x_regwr = 0; x_memrd = 0; x_setflags = 0; m_memrd = 0; imiss = 0; dmiss = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    next_cycle();
  endtask

  // Reference model. Modes: 0 running, 1 waiting on D-cache, 2 waiting on
  // I-cache, 3 halted. Produces {ctl, halted, mode} and the following mode.
  task automatic model_eval(input int mode, output logic [8:0] exp, output int nxt);
    bit reads_ld, flags_dep, target_dep, stall;
    bit pc, ifw, fl, bb, back;
    reads_ld   = x_memrd && x_regwr && x_rd != 0 &&
                 ((d_rs_en && d_rs == x_rd) || (d_rt_en && d_rt == x_rd));
    flags_dep  = d_br_cond && x_setflags;
    target_dep = d_br_reg && d_rs != 0 &&
                 ((x_regwr && d_rs == x_rd) || (m_memrd && d_rs == m_rd));
    stall = reads_ld || flags_dep || target_dep;
    back = !dmiss;
    nxt = mode;
    pc = 1; ifw = 1; fl = 0; bb = 0;
    if (mode == 3) begin
      pc = 0; ifw = 0; fl = !dmiss;
    end else if (dmiss) begin
      nxt = 1; pc = 0; ifw = 0;
    end else begin
      nxt = imiss ? 2 : 0;
      if (imiss) begin pc = 0; ifw = 0; end
      if (stall) begin
        pc = 0; ifw = 0; bb = 1;
      end else if (d_br_taken) begin
        pc = 1; fl = 1;
      end else begin
        fl = imiss;
        if (d_halt) begin nxt = 3; pc = 0; ifw = 0; fl = 1; end
      end
    end
    exp = {pc, ifw, fl, bb, back, back, mode == 3, 2'(mode)};
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({ctl, halted, state} !== {6'b110011, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset: got ctl=%b halted=%b state=%0d, want ctl=110011 halted=0 state=0",
               ctl, halted, state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_load_use();
    idle();
    x_memrd = 1; x_regwr = 1; x_rd = 4'd3; d_rs_en = 1; d_rs = 4'd3;
    @(negedge clk);
    n_checks++;
    if (ctl !== 6'b000111) begin
      n_fail++;
      $display("FAIL load_use_stall: got ctl=%b, want 000111", ctl);
    end
    next_cycle();
    // LW has moved on; a bubble now sits in EX.
    x_memrd = 0; x_regwr = 0; x_rd = '0;
    @(negedge clk);
    n_checks++;
    if (ctl !== 6'b110011) begin
      n_fail++;
      $display("FAIL load_use_release: got ctl=%b, want 110011", ctl);
    end
    next_cycle();
  endtask

  task automatic test_no_hazard_cases();
    logic [5:0] want [5];
    for (int i = 0; i < 5; i++) begin
      idle();
      case (i)
        0: begin x_memrd = 1; x_regwr = 1; x_rd = 0; d_rs_en = 1; d_rs = 0; want[i] = 6'b110011; end
        1: begin x_memrd = 1; x_regwr = 1; x_rd = 5; d_rt = 5; d_rs_en = 1; d_rs = 1;
                 want[i] = 6'b110011; end
        2: begin d_br_cond = 1; x_setflags = 1; d_br_taken = 1; want[i] = 6'b000111; end
        3: begin d_br_reg = 1; d_rs = 4; m_memrd = 1; m_rd = 4; want[i] = 6'b000111; end
        default: begin d_br_reg = 1; d_rs = 0; x_regwr = 1; x_rd = 0; d_br_taken = 1;
                       want[i] = 6'b111011; end
      endcase
      @(negedge clk);
      n_checks++;
      if (ctl !== want[i]) begin
        n_fail++;
        $display("FAIL dep_case%0d: got ctl=%b, want %b", i, ctl, want[i]);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_dmiss();
    idle();
    for (int i = 0; i < 10; i++) begin
      dmiss = 1;
      @(negedge clk);
      n_checks++;
      if (ctl !== 6'b000000 || state !== ((i == 0) ? 2'd0 : 2'd1)) begin
        n_fail++;
        $display("FAIL dmiss_freeze cyc%0d: got ctl=%b state=%0d, want ctl=000000 state=%0d",
                 i, ctl, state, (i == 0) ? 0 : 1);
      end
      next_cycle();
    end
    dmiss = 0;
    @(negedge clk);
    n_checks++;
    if (ctl !== 6'b110011 || state !== 2'd1) begin
      n_fail++;
      $display("FAIL dmiss_exit: got ctl=%b state=%0d, want ctl=110011 state=1", ctl, state);
    end
    next_cycle();
    n_checks++;
    if (state !== 2'd0) begin
      n_fail++;
      $display("FAIL dmiss_run: got state=%0d, want 0", state);
    end
  endtask

  task automatic test_imiss_branch();
    idle();
    for (int i = 0; i < 4; i++) begin
      imiss = 1;
      d_br_taken = (i == 1);
      @(negedge clk);
      n_checks++;
      if (ifid_flush !== 1'b1 || pc_we !== (i == 1) || idex_bubble !== 1'b0 || exmem_we !== 1'b1)
      begin
        n_fail++;
        $display("FAIL imiss_branch cyc%0d: got flush=%b pc_we=%b bubble=%b exmem=%b", i,
                 ifid_flush, pc_we, idex_bubble, exmem_we);
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_dual_miss();
    logic [1:0] want_state [7];
    bit         im_seq [7];
    bit         dm_seq [7];
    want_state = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    im_seq     = '{1, 1, 1, 1, 1, 0, 0};
    dm_seq     = '{1, 1, 1, 0, 0, 0, 0};
    idle();
    for (int i = 0; i < 7; i++) begin
      imiss = im_seq[i];
      dmiss = dm_seq[i];
      @(negedge clk);
      n_checks++;
      if (state !== want_state[i]) begin
        n_fail++;
        $display("FAIL dual_miss cyc%0d: got state=%0d, want %0d", i, state, want_state[i]);
      end
      next_cycle();
    end
    // Reset in the middle of a D-miss wait.
    dmiss = 1;
    next_cycle();
    dmiss = 0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 2'd0 || pc_we !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_miss: got state=%0d pc_we=%b, want state=0 pc_we=1", state, pc_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_halt();
    idle();
    d_halt = 1;
    @(negedge clk);
    n_checks++;
    if (pc_we !== 1'b0 || ifid_flush !== 1'b1 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_detect: got pc_we=%b flush=%b halted=%b, want 0 1 0",
               pc_we, ifid_flush, halted);
    end
    next_cycle();
    d_halt = 0;
    for (int i = 0; i < 3; i++) begin
      d_br_taken = (i == 1);
      @(negedge clk);
      n_checks++;
      if (halted !== 1'b1 || pc_we !== 1'b0 || state !== 2'd3 || memwb_we !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_hold cyc%0d: got halted=%b pc_we=%b state=%0d memwb=%b", i,
                 halted, pc_we, state, memwb_we);
      end
      next_cycle();
    end
    idle();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 2'd0 || halted !== 1'b0 || pc_we !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_reset: got state=%0d halted=%b pc_we=%b, want 0 0 1",
               state, halted, pc_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_random();
    int mode = 0;
    int nxt;
    logic [8:0] exp;
    for (int n = 0; n < 400; n++) begin
      d_rs = 4'($urandom_range(0, 3));  d_rt = 4'($urandom_range(0, 3));
      x_rd = 4'($urandom_range(0, 3));  m_rd = 4'($urandom_range(0, 3));
      d_rs_en = 1'($urandom);  d_rt_en = 1'($urandom);
      d_br_cond = ($urandom_range(0, 3) == 0);  d_br_reg = ($urandom_range(0, 3) == 0);
      d_br_taken = ($urandom_range(0, 3) == 0); d_halt = ($urandom_range(0, 29) == 0);
      x_regwr = 1'($urandom); x_memrd = 1'($urandom); x_setflags = ($urandom_range(0, 3) == 0);
      m_memrd = 1'($urandom);
      imiss = ($urandom_range(0, 5) == 0);  dmiss = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      model_eval(mode, exp, nxt);
      n_checks++;
      if ({ctl, halted, state} !== exp) begin
        n_fail++;
        $display("FAIL random cyc%0d: got {ctl,halted,state}=%b, want %b", n,
                 {ctl, halted, state}, exp);
      end
      next_cycle();
      mode = nxt;
      // Leave HALT after a few cycles so the run keeps exercising RUN.
      if (mode == 3 && $urandom_range(0, 3) == 0) begin
        idle();
        pulse_reset();
        mode = 0;
      end
    end
    idle();
  endtask

`ifdef HAZ_PERF_EN
  task automatic test_perf();
    idle();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      x_memrd = 1; x_regwr = 1; x_rd = 4'd7; d_rt_en = 1; d_rt = 4'd7;
      next_cycle();
      idle();
      next_cycle();
    end
    dmiss = 1;
    next_cycle();
    next_cycle();
    dmiss = 0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (cnt_lu !== 16'd3 || cnt_dmiss !== 16'd2 || cnt_imiss !== 16'd0) begin
      n_fail++;
      $display("FAIL perf_counts: got lu=%0d dmiss=%0d imiss=%0d, want 3 2 0",
               cnt_lu, cnt_dmiss, cnt_imiss);
    end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard_cases();
    test_dmiss();
    test_imiss_branch();
    test_dual_miss();
    test_halt();
    test_random();
`ifdef HAZ_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
